sprite_line_select: RTL and testbench

- Per-scanline sprite selector sitting directly downstream of the X-position sprite sorter.
- On each line_start it pulses the sorter's load and waits for the sort to settle.
- It then walks the sorted index list left-to-right and checks each sprite's Y against the upcoming line.
- It writes up to MAX_PER_LINE hit indices, in ascending-X order, into the renderer's line list RAM.

---
 rtl/sprite_line_select.sv | 165 ++++++++++++++++
 tb/tb_sprite_line_select.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_line_select.sv
// Per-scanline sprite selector: reloads the X sorter, scans the sorted list and
// writes up to MAX_PER_LINE Y-hits to the line list. Optional macro: SPRITE_HIDE_Y0_EN.
module sprite_line_select #(
    parameter int unsigned SPRITES      = 128,
    parameter int unsigned IDX_BITS     = 7,
    parameter int unsigned Y_BITS       = 9,
    parameter int unsigned SPR_H        = 16,
    parameter int unsigned MAX_PER_LINE = 16,
    parameter int unsigned CNT_BITS     = 5,
    parameter int unsigned SORT_CYCLES  = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         line_start,
    input  logic [Y_BITS-1:0]            next_line,
    output logic                         sort_load,
    input  logic [IDX_BITS*SPRITES-1:0]  sort_idx,
    output logic [IDX_BITS-1:0]          y_addr,
    input  logic [Y_BITS-1:0]            y_data,
    output logic                         list_we,
    output logic [CNT_BITS-2:0]          list_addr,
    output logic [IDX_BITS-1:0]          list_data,
    output logic [CNT_BITS-1:0]          list_count,
    output logic                         overflow,
    output logic                         done
);

    localparam int unsigned SC_BITS = $clog2(SORT_CYCLES + 1);
    localparam int unsigned P_BITS  = $clog2(SPRITES + 1);

    typedef enum logic [2:0] {IDLE, LOAD, SORT, SCAN, DONE} state_t;

    state_t               state, state_next;
    logic [Y_BITS-1:0]    line_r, line_next;
    logic [SC_BITS-1:0]   sort_cnt, cnt_next;
    logic [P_BITS-1:0]    p, p_next;
    logic [IDX_BITS-1:0]  y_addr_next;
    logic [IDX_BITS-1:0]  cmp_idx, cmp_idx_next;
    logic                 cmp_valid, cmp_valid_next;
    logic                 cmp_last, cmp_last_next;
    logic [CNT_BITS-1:0]  count_next;
    logic                 ovf_next, done_next, sort_load_next;
    logic [Y_BITS-1:0]    diff;
    logic                 hit;

    // Wrap-around distance from sprite top to the line being built
    assign diff = line_r - y_data;
`ifdef SPRITE_HIDE_Y0_EN
    assign hit  = (diff < Y_BITS'(SPR_H)) && (y_data != '0);
`else
    assign hit  = (diff < Y_BITS'(SPR_H));
`endif

    assign list_addr = list_count[CNT_BITS-2:0];
    assign list_data = cmp_idx;

    always_comb begin
        state_next     = state;
        line_next      = line_r;
        cnt_next       = sort_cnt;
        p_next         = p;
        y_addr_next    = y_addr;
        cmp_idx_next   = cmp_idx;
        cmp_valid_next = 1'b0;
        cmp_last_next  = 1'b0;
        count_next     = list_count;
        ovf_next       = overflow;
        done_next      = done;
        list_we        = 1'b0;

        case (state)
            LOAD: begin
                state_next = SORT;
                cnt_next   = '0;
            end
            SORT: begin
                if (sort_cnt == SC_BITS'(SORT_CYCLES - 1)) begin
                    state_next  = SCAN;
                    p_next      = '0;
                    y_addr_next = sort_idx[IDX_BITS-1:0];
                end else begin
                    cnt_next = sort_cnt + 1'b1;
                end
            end
            SCAN: begin
                // Issue stage: y_addr holds entry p, its Y arrives next cycle
                if (32'(p) < SPRITES) begin
                    cmp_valid_next = 1'b1;
                    cmp_last_next  = (32'(p) == SPRITES - 1);
                    cmp_idx_next   = y_addr;
                    p_next         = p + 1'b1;
                    if (32'(p) + 32'd1 < SPRITES)
                        y_addr_next = sort_idx[IDX_BITS*(32'(p) + 32'd1) +: IDX_BITS];
                end
                // Compare stage for the index issued last cycle
                if (cmp_valid) begin
                    if (hit && (list_count < CNT_BITS'(MAX_PER_LINE))) begin
                        list_we    = 1'b1;
                        count_next = list_count + 1'b1;
                    end else if (hit) begin
                        ovf_next   = 1'b1;
                        state_next = DONE;
                        done_next  = 1'b1;
                    end
                    if (cmp_last) begin
                        state_next = DONE;
                        done_next  = 1'b1;
                    end
                end
            end
            default: ;
        endcase

        // Drop any in-flight compare when leaving SCAN
        if (state_next != SCAN) begin
            cmp_valid_next = 1'b0;
            cmp_last_next  = 1'b0;
        end

        // A new line request restarts from any state
        if (line_start) begin
            state_next     = LOAD;
            line_next      = next_line;
            count_next     = '0;
            ovf_next       = 1'b0;
            done_next      = 1'b0;
            list_we        = 1'b0;
            cmp_valid_next = 1'b0;
            cmp_last_next  = 1'b0;
        end

        sort_load_next = (state_next == LOAD);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            line_r     <= '0;
            sort_cnt   <= '0;
            p          <= '0;
            y_addr     <= '0;
            cmp_idx    <= '0;
            cmp_valid  <= 1'b0;
            cmp_last   <= 1'b0;
            list_count <= '0;
            overflow   <= 1'b0;
            done       <= 1'b0;
            sort_load  <= 1'b0;
        end else begin
            state      <= state_next;
            line_r     <= line_next;
            sort_cnt   <= cnt_next;
            p          <= p_next;
            y_addr     <= y_addr_next;
            cmp_idx    <= cmp_idx_next;
            cmp_valid  <= cmp_valid_next;
            cmp_last   <= cmp_last_next;
            list_count <= count_next;
            overflow   <= ovf_next;
            done       <= done_next;
            sort_load  <= sort_load_next;
        end
    end

endmodule

// File: tb/tb_sprite_line_select.sv
// Bench for sprite_line_select: directed lines checked cycle-by-cycle against a list-level model.
module tb_sprite_line_select;

    localparam int unsigned SPRITES      = 128;
    localparam int unsigned IDX_BITS     = 7;
    localparam int unsigned Y_BITS       = 9;
    localparam int unsigned SPR_H        = 16;
    localparam int unsigned MAX_PER_LINE = 16;
    localparam int unsigned CNT_BITS     = 5;
    localparam int unsigned SORT_CYCLES  = 64;

    logic                        clk = 1'b0;
    logic                        reset;
    logic                        line_start;
    logic [Y_BITS-1:0]           next_line;
    logic                        sort_load;
    logic [IDX_BITS*SPRITES-1:0] sort_idx;
    logic [IDX_BITS-1:0]         y_addr;
    logic [Y_BITS-1:0]           y_data;
    logic                        list_we;
    logic [CNT_BITS-2:0]         list_addr;
    logic [IDX_BITS-1:0]         list_data;
    logic [CNT_BITS-1:0]         list_count;
    logic                        overflow;
    logic                        done;

    sprite_line_select #(
        .SPRITES(SPRITES), .IDX_BITS(IDX_BITS), .Y_BITS(Y_BITS), .SPR_H(SPR_H),
        .MAX_PER_LINE(MAX_PER_LINE), .CNT_BITS(CNT_BITS), .SORT_CYCLES(SORT_CYCLES)
    ) dut (
        .clk(clk), .reset(reset), .line_start(line_start), .next_line(next_line),
        .sort_load(sort_load), .sort_idx(sort_idx), .y_addr(y_addr), .y_data(y_data),
        .list_we(list_we), .list_addr(list_addr), .list_data(list_data),
        .list_count(list_count), .overflow(overflow), .done(done)
    );

    always #5 clk = ~clk;

    int         order [SPRITES];
    logic [8:0] yv    [SPRITES];

    always_comb begin
        for (int i = 0; i < int'(SPRITES); i++)
            sort_idx[i*IDX_BITS +: IDX_BITS] = IDX_BITS'(order[i]);
    end

    // Sprite attribute RAM with one-cycle read latency
    always @(posedge clk) y_data <= yv[y_addr];

    int n_pass = 0;
    int n_chk  = 0;

    int exp_idx[$];
    int exp_rel[$];
    int exp_ovf;
    int exp_done_rel;
    int got_q[$];

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic bit model_hit(input int line, input int y);
        int d;
        d = ((line - y) % 512 + 512) % 512;
`ifdef SPRITE_HIDE_Y0_EN
        if (y == 0) return 1'b0;
`endif
        return d < int'(SPR_H);
    endfunction

    // Expected list, write cycles and done cycle relative to the line_start cycle
    task automatic compute_model(input int line);
        exp_idx.delete();
        exp_rel.delete();
        exp_ovf      = 0;
        exp_done_rel = 3 + int'(SORT_CYCLES) + int'(SPRITES);
        for (int p = 0; p < int'(SPRITES); p++) begin
            if (model_hit(line, int'(yv[order[p]]))) begin
                if (exp_idx.size() < int'(MAX_PER_LINE)) begin
                    exp_idx.push_back(order[p]);
                    exp_rel.push_back(3 + int'(SORT_CYCLES) + p);
                end else begin
                    exp_ovf      = 1;
                    exp_done_rel = 4 + int'(SORT_CYCLES) + p;
                    break;
                end
            end
        end
    endtask

    task automatic pulse_line(input int line);
        @(negedge clk);
        line_start = 1'b1;
        next_line  = Y_BITS'(line);
        @(negedge clk);
        line_start = 1'b0;
    endtask

    task automatic start_only(input int line, input int n);
        pulse_line(line);
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic run_line(input int line, output int done_rel);
        int  rel;
        int  k;
        bit  exp_we;
        bit  seen;
        compute_model(line);
        got_q.delete();
        pulse_line(line);
        rel = 1; k = 0; seen = 0; done_rel = -1;
        while (rel < 400) begin
            check("sort_load", int'(sort_load), int'(rel == 1));
            exp_we = (k < exp_rel.size()) && (exp_rel[k] == rel);
            check("list_we", int'(list_we), int'(exp_we));
            if (list_we) got_q.push_back(int'(list_data));
            if (list_we && exp_we) begin
                check("list_addr", int'(list_addr), k);
                check("list_data", int'(list_data), exp_idx[k]);
                k++;
            end
            if (done) begin
                seen = 1;
                done_rel = rel;
                check("done_cycle", rel, exp_done_rel);
                break;
            end
            @(negedge clk);
            rel++;
        end
        if (!seen) check("done_timeout", 0, 1);
        check("writes_seen", k, exp_idx.size());
        check("list_count", int'(list_count), exp_idx.size());
        check("overflow", int'(overflow), exp_ovf);
        @(negedge clk);
        check("done_hold", int'(done), 1);
        check("we_after_done", int'(list_we), 0);
        check("count_hold", int'(list_count), exp_idx.size());
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_sort_load"}, int'(sort_load), 0);
        check({tag, "_list_we"}, int'(list_we), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_overflow"}, int'(overflow), 0);
        check({tag, "_list_count"}, int'(list_count), 0);
        check({tag, "_y_addr"}, int'(y_addr), 0);
        check({tag, "_list_addr"}, int'(list_addr), 0);
        check({tag, "_list_data"}, int'(list_data), 0);
    endtask

    task automatic set_all_y(input int y);
        for (int i = 0; i < int'(SPRITES); i++) yv[i] = 9'(y);
    endtask

    task automatic set_identity();
        for (int i = 0; i < int'(SPRITES); i++) order[i] = i;
    endtask

    // Sorted list 5,2,9 then the remaining indices ascending
    task automatic set_order_test1();
        int n;
        order[0] = 5; order[1] = 2; order[2] = 9;
        n = 3;
        for (int i = 0; i < int'(SPRITES); i++) begin
            if (i != 5 && i != 2 && i != 9) begin
                order[n] = i;
                n++;
            end
        end
    endtask

    initial begin
        int d;
        reset      = 1'b1;
        line_start = 1'b0;
        next_line  = '0;
        set_identity();
        set_all_y(300);
        repeat (3) @(negedge clk);
        check_zero("reset");
        reset = 1'b0;

        // Basic order test
        set_order_test1();
        yv[5] = 9'd100; yv[2] = 9'd100; yv[9] = 9'd100;
        run_line(108, d);
        check("t1_done_rel", d, 195);
        check("t1_count", int'(list_count), 3);
        check("t1_ovf", int'(overflow), 0);
        check("t1_nwrites", got_q.size(), 3);
        check("t1_e0", got_q.size() > 0 ? got_q[0] : -1, 5);
        check("t1_e1", got_q.size() > 1 ? got_q[1] : -1, 2);
        check("t1_e2", got_q.size() > 2 ? got_q[2] : -1, 9);

        // Height boundaries
        run_line(115, d);
        check("b115_count", int'(list_count), 3);
        run_line(116, d);
        check("b116_count", int'(list_count), 0);
        run_line(99, d);
        check("b99_count", int'(list_count), 0);

        // Abort mid-scan after three writes
        start_only(108, 72);
        check("abort_pre_count", int'(list_count), 3);
        check("abort_pre_done", int'(done), 0);
        run_line(108, d);
        check("abort_done_rel", d, 195);
        check("abort_count", int'(list_count), 3);

        // Reset while sorting
        start_only(40, 20);
        reset = 1'b1;
        @(negedge clk);
        check_zero("rst_sort");
        reset = 1'b0;
        @(negedge clk);
        check("rst_idle_load", int'(sort_load), 0);
        check("rst_idle_done", int'(done), 0);

        // Wrap around line 0
        set_all_y(300);
        yv[7] = 9'd510;
        run_line(3, d);
        check("wrap3_count", int'(list_count), 1);
        check("wrap3_e0", got_q.size() > 0 ? got_q[0] : -1, 7);
        run_line(14, d);
        check("wrap14_count", int'(list_count), 0);

        // Y=0 sprite
        yv[7] = 9'd0;
        run_line(3, d);
`ifdef SPRITE_HIDE_Y0_EN
        check("y0_count", int'(list_count), 0);
`else
        check("y0_count", int'(list_count), 1);
`endif

        // Overflow
        set_identity();
        set_all_y(300);
        for (int i = 0; i < 20; i++) yv[i] = 9'd50;
        run_line(55, d);
        check("ovf_done_rel", d, 84);
        check("ovf_count", int'(list_count), 16);
        check("ovf_flag", int'(overflow), 1);
        check("ovf_nwrites", got_q.size(), 16);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
